arbitro_vc_destino: RTL and testbench
=====================================

Name: arbitro_vc_destino

Overview:
- Moves words from the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1).
- VC0 has priority, with a burst-limited starvation guard for VC1. Destination FIFO almost-full flags provide backpressure.
- Runs only while the flow-control FSM reports the active state; sits between the VC FIFO bank and the D FIFO bank.

Parameters:
- DATA_WIDTH, 6, word width of VC/D FIFO data.
- DEST_BIT, 4, bit of the head word that selects the destination: 0 -> D0, 1 -> D1.
- BURST, 4, maximum consecutive VC0 grants while VC1 is eligible; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- active  input  1  FSM in active state; enables new grants.
- vc0_empty  input  1  VC0 FIFO empty.
- vc1_empty  input  1  VC1 FIFO empty.
- vc0_data  input  DATA_WIDTH  VC0 head word, show-ahead (valid whenever !vc0_empty).
- vc1_data  input  DATA_WIDTH  VC1 head word, show-ahead.
- d0_almost_full  input  1  D0 at or above its threshold; asserted with >= 1 free entry remaining.
- d1_almost_full  input  1  D1 almost full, same rule.
- vc0_pop  output  1  combinational; consumes the VC0 head this cycle.
- vc1_pop  output  1  combinational; consumes the VC1 head.
- d0_push  output  1  registered; writes d_data into D0.
- d1_push  output  1  registered; writes d_data into D1.
- d_data  output  DATA_WIDTH  registered; word being pushed.
- grant_vc  output  1  registered; VC of the last grant (0/1).
- blocked  output  1  registered; a VC was non-empty but no VC was eligible last cycle.

Behaviour:
- Reset (reset=0, asynchronous): all registered outputs 0, burst counter 0, pipeline valid 0. vc0_pop/vc1_pop are forced to 0 while reset=0. An in-flight word is discarded, not pushed.
- Eligibility: eligN = active && !vcN_empty && !dK_almost_full, where K = vcN_data[DEST_BIT].
- Grant (combinational, same cycle):
  - Only elig0: grant VC0.
  - Only elig1: grant VC1.
  - Both: grant VC0 unless burst_cnt == BURST, then grant VC1.
  - Neither: no pop.
- At most one pop per cycle; never both.
- Burst counter, width clog2(BURST+1):
  - Increments on a VC0 grant while elig1=1.
  - Clears on any VC1 grant.
  - Holds otherwise.
  - Never exceeds BURST.
- Pipeline, latency 1:
  - On a grant at edge N, the popped head word is registered into d_data. Exactly one of d0_push/d1_push is high during cycle N+1, chosen by the word's DEST_BIT.
  - Push is high for exactly one cycle per pop. Back-to-back grants give continuous pushes, throughput 1 word/clk.
- Backpressure:
  - Almost-full is checked before the pop, so the single in-flight word always has a free slot.
  - A word already registered is pushed even if almost_full rises during cycle N+1.
- active deasserting mid-stream: no new pops from that cycle on; the in-flight word is still pushed. Burst counter holds its value.
- blocked: registered each cycle = (!vc0_empty || !vc1_empty) && !(elig0 || elig1) && active.
- grant_vc updates only on a grant; otherwise it holds.
- Empty/pop interaction: a pop is never issued to an empty VC, so underflow is impossible by construction.
- Head-of-line: a VC whose head targets a full destination is skipped. The other VC may proceed, including to the other destination.

Test Plan:
- Reset then active=1; VC0 holds 6'h05, 6'h13; VC1 empty; D not full -> vc0_pop on two consecutive cycles. Next cycles: d0_push with d_data=6'h05, then d1_push with d_data=6'h13. grant_vc=0.
- Both VCs continuously full of 6'h01, BURST=4, D not full -> grant pattern VC0 x4, VC1 x1, repeating. Burst counter never exceeds 4.
- VC0 head 6'h12 (to D1), d1_almost_full=1, VC1 head 6'h03 -> only vc1_pop asserted, then d0_push with 6'h03. After VC1 drains, blocked=1 until d1_almost_full=0; then VC0 pops.
- Grant at edge N with active dropped at N+1 -> word pushed at N+1, no further pops while active=0. Resumes in the cycle active returns to 1.
- reset=0 asserted mid-cycle right after a pop -> pushes, d_data, grant_vc, blocked and the counter clear immediately; the in-flight word is never pushed.
- Both VCs empty, active=1 -> no pops, no pushes, blocked=0.

Source files
------------

// File: rtl/arbitro_vc_destino_if.sv
// Bundle of the VC-FIFO-side and destination-FIFO-side signals of the VC-to-destination arbiter.
// The slave modport is the arbiter's view. The master modport is the FIFO banks' (or bench's) view.
`timescale 1ns/1ps
interface arbitro_vc_destino_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  active;
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [DATA_WIDTH-1:0] vc0_data;
    logic [DATA_WIDTH-1:0] vc1_data;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  vc0_pop;
    logic                  vc1_pop;
    logic                  d0_push;
    logic                  d1_push;
    logic [DATA_WIDTH-1:0] d_data;
    logic                  grant_vc;
    logic                  blocked;

    modport slave (
        input  active, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, d_data, grant_vc, blocked
    );

    modport master (
        output active, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, d_data, grant_vc, blocked
    );
endinterface

// File: rtl/arbitro_vc_destino.sv
// Moves head words from VC0/VC1 into D0/D1. VC0 has priority, and a burst counter guards VC1 against starvation.
// Pops are combinational. The push toward the destination is registered one cycle later.
`timescale 1ns/1ps
module arbitro_vc_destino #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int BURST      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    arbitro_vc_destino_if.slave  bus
);
    localparam int CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    logic                  elig0_s;
    logic                  elig1_s;
    logic                  grant0_s;
    logic                  grant1_s;
    logic                  blocked_s;
    logic [DATA_WIDTH-1:0] pop_word_s;
    logic [CNT_W-1:0]      burst_cnt_r;
    logic                  d0_push_r;
    logic                  d1_push_r;
    logic [DATA_WIDTH-1:0] d_data_r;
    logic                  grant_vc_r;
    logic                  blocked_r;

    // Almost-full of the destination selected by the head word's DEST_BIT
    function automatic logic dest_full(input logic [DATA_WIDTH-1:0] word,
                                       input logic af0, input logic af1);
        if (word[DEST_BIT]) begin
            return af1;
        end else begin
            return af0;
        end
    endfunction

    // Eligibility of each VC and the blocked condition
    always_comb begin
        elig0_s   = bus.active && !bus.vc0_empty &&
                    !dest_full(bus.vc0_data, bus.d0_almost_full, bus.d1_almost_full);
        elig1_s   = bus.active && !bus.vc1_empty &&
                    !dest_full(bus.vc1_data, bus.d0_almost_full, bus.d1_almost_full);
        blocked_s = (!bus.vc0_empty || !bus.vc1_empty) && !(elig0_s || elig1_s) && bus.active;
    end

    // Grant selection; VC1 wins a tie only once VC0 has used up its burst
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else begin
            case ({elig0_s, elig1_s})
                2'b11: begin
                    if (burst_cnt_r == BURST_C) begin
                        grant1_s = 1'b1;
                    end else begin
                        grant0_s = 1'b1;
                    end
                end
                2'b10:   grant0_s = 1'b1;
                2'b01:   grant1_s = 1'b1;
                default: begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
            endcase
        end
    end

    assign pop_word_s  = grant1_s ? bus.vc1_data : bus.vc0_data;
    assign bus.vc0_pop = grant0_s;
    assign bus.vc1_pop = grant1_s;

    // Burst counter: counts VC0 wins while VC1 is waiting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt_r <= {CNT_W{1'b0}};
        end else if (grant1_s) begin
            burst_cnt_r <= {CNT_W{1'b0}};
        end else if (grant0_s && elig1_s && (burst_cnt_r != BURST_C)) begin
            burst_cnt_r <= burst_cnt_r + CNT_W'(1);
        end else begin
            burst_cnt_r <= burst_cnt_r;
        end
    end

    // Push pipeline stage plus the grant and blocked status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d0_push_r  <= 1'b0;
            d1_push_r  <= 1'b0;
            d_data_r   <= {DATA_WIDTH{1'b0}};
            grant_vc_r <= 1'b0;
            blocked_r  <= 1'b0;
        end else begin
            blocked_r <= blocked_s;
            if (grant0_s || grant1_s) begin
                d0_push_r  <= !pop_word_s[DEST_BIT];
                d1_push_r  <= pop_word_s[DEST_BIT];
                d_data_r   <= pop_word_s;
                grant_vc_r <= grant1_s;
            end else begin
                d0_push_r  <= 1'b0;
                d1_push_r  <= 1'b0;
                d_data_r   <= d_data_r;
                grant_vc_r <= grant_vc_r;
            end
        end
    end

    assign bus.d0_push  = d0_push_r;
    assign bus.d1_push  = d1_push_r;
    assign bus.d_data   = d_data_r;
    assign bus.grant_vc = grant_vc_r;
    assign bus.blocked  = blocked_r;
endmodule

// File: tb/tb_arbitro_vc_destino.sv
// Directed bench for arbitro_vc_destino: the VC FIFOs are modelled as queues and every expected value is hand-derived.
`timescale 1ns/1ps
module tb_arbitro_vc_destino;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic       fill0;
    logic       fill1;
    logic [5:0] fill_word0;
    logic [5:0] fill_word1;

    arbitro_vc_destino_if #(.DATA_WIDTH(6)) ifc ();

    arbitro_vc_destino #(.DATA_WIDTH(6), .DEST_BIT(4), .BURST(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic update_heads();
        ifc.vc0_empty = fill0 ? 1'b0 : (q0.size() == 0);
        ifc.vc0_data  = fill0 ? fill_word0 : ((q0.size() != 0) ? q0[0] : 6'h00);
        ifc.vc1_empty = fill1 ? 1'b0 : (q1.size() == 0);
        ifc.vc1_data  = fill1 ? fill_word1 : ((q1.size() != 0) ? q1[0] : 6'h00);
    endtask

    // One clock: the FIFO heads advance on the pops seen before the edge
    task automatic tick();
        logic p0;
        logic p1;
        p0 = ifc.vc0_pop;
        p1 = ifc.vc1_pop;
        @(posedge clk);
        #1;
        if (p0 && !fill0 && q0.size() != 0) void'(q0.pop_front());
        if (p1 && !fill1 && q1.size() != 0) void'(q1.pop_front());
        update_heads();
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        fill0 = 1'b0;
        fill1 = 1'b0;
        fill_word0 = 6'h01;
        fill_word1 = 6'h01;
        rst_n = 1'b0;
        ifc.active = 1'b0;
        ifc.d0_almost_full = 1'b0;
        ifc.d1_almost_full = 1'b0;
        update_heads();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("rst_d0_push", ifc.d0_push, 1'b0);
        check("rst_d1_push", ifc.d1_push, 1'b0);
        check("rst_d_data", ifc.d_data, 6'h00);
        check("rst_grant_vc", ifc.grant_vc, 1'b0);
        check("rst_blocked", ifc.blocked, 1'b0);
        check("rst_cnt", dut.burst_cnt_r, 3'd0);

        // Two VC0 words to different destinations
        ifc.active = 1'b1;
        q0.push_back(6'h05);
        q0.push_back(6'h13);
        update_heads();
        #1;
        check("t1_pop0_a", ifc.vc0_pop, 1'b1);
        check("t1_pop1_a", ifc.vc1_pop, 1'b0);
        tick();
        check("t1_d0_push", ifc.d0_push, 1'b1);
        check("t1_d1_push_lo", ifc.d1_push, 1'b0);
        check("t1_data_a", ifc.d_data, 6'h05);
        check("t1_grant_vc", ifc.grant_vc, 1'b0);
        check("t1_pop0_b", ifc.vc0_pop, 1'b1);
        tick();
        check("t1_d1_push", ifc.d1_push, 1'b1);
        check("t1_d0_push_lo", ifc.d0_push, 1'b0);
        check("t1_data_b", ifc.d_data, 6'h13);
        check("t1_pop0_idle", ifc.vc0_pop, 1'b0);
        tick();
        check("idle_d0_push", ifc.d0_push, 1'b0);
        check("idle_d1_push", ifc.d1_push, 1'b0);
        check("idle_blocked", ifc.blocked, 1'b0);
        check("idle_pop1", ifc.vc1_pop, 1'b0);

        // Both VCs always full: VC0 x4 then VC1 x1
        fill0 = 1'b1;
        fill1 = 1'b1;
        update_heads();
        #1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_pop1_%0d", i), ifc.vc1_pop, (i % 5 == 4) ? 1'b1 : 1'b0);
            check($sformatf("t2_pop0_%0d", i), ifc.vc0_pop, (i % 5 == 4) ? 1'b0 : 1'b1);
            tick();
            check($sformatf("t2_gvc_%0d", i), ifc.grant_vc, (i % 5 == 4) ? 1'b1 : 1'b0);
            check($sformatf("t2_push_%0d", i), ifc.d0_push, 1'b1);
            check($sformatf("t2_cnt_%0d", i), dut.burst_cnt_r, (i % 5 == 4) ? 0 : (i % 5) + 1);
        end
        fill0 = 1'b0;
        fill1 = 1'b0;
        update_heads();
        #1;
        tick();
        check("t2_drain", ifc.d0_push, 1'b0);

        // Head-of-line: VC0 head aims at the full D1, so VC1 goes first
        ifc.d1_almost_full = 1'b1;
        q0.push_back(6'h12);
        q1.push_back(6'h03);
        update_heads();
        #1;
        check("t3_pop1", ifc.vc1_pop, 1'b1);
        check("t3_pop0", ifc.vc0_pop, 1'b0);
        tick();
        check("t3_d0_push", ifc.d0_push, 1'b1);
        check("t3_data", ifc.d_data, 6'h03);
        check("t3_grant_vc", ifc.grant_vc, 1'b1);
        check("t3_blocked_a", ifc.blocked, 1'b0);
        check("t3_pop0_b", ifc.vc0_pop, 1'b0);
        tick();
        check("t3_blocked_b", ifc.blocked, 1'b1);
        check("t3_nopush", ifc.d0_push | ifc.d1_push, 1'b0);
        tick();
        check("t3_blocked_c", ifc.blocked, 1'b1);
        ifc.d1_almost_full = 1'b0;
        #1;
        check("t3_pop0_c", ifc.vc0_pop, 1'b1);
        tick();
        check("t3_d1_push", ifc.d1_push, 1'b1);
        check("t3_data_b", ifc.d_data, 6'h12);
        check("t3_grant_vc_b", ifc.grant_vc, 1'b0);
        check("t3_blocked_d", ifc.blocked, 1'b0);
        tick();

        // active drops right after a grant
        q0.push_back(6'h05);
        q0.push_back(6'h07);
        update_heads();
        #1;
        check("t4_pop0_a", ifc.vc0_pop, 1'b1);
        tick();
        ifc.active = 1'b0;
        #1;
        check("t4_push", ifc.d0_push, 1'b1);
        check("t4_data", ifc.d_data, 6'h05);
        check("t4_pop0_off", ifc.vc0_pop, 1'b0);
        tick();
        check("t4_nopush", ifc.d0_push, 1'b0);
        check("t4_blocked", ifc.blocked, 1'b0);
        check("t4_pop0_off2", ifc.vc0_pop, 1'b0);
        tick();
        ifc.active = 1'b1;
        #1;
        check("t4_pop0_on", ifc.vc0_pop, 1'b1);
        tick();
        check("t4_push_b", ifc.d0_push, 1'b1);
        check("t4_data_b", ifc.d_data, 6'h07);
        tick();

        // Reset asserted mid-cycle with a pop pending
        fill0 = 1'b1;
        fill1 = 1'b1;
        fill_word1 = 6'h13;
        update_heads();
        #1;
        tick();
        tick();
        check("t5_cnt_pre", dut.burst_cnt_r, 3'd2);
        check("t5_push_pre", ifc.d0_push, 1'b1);
        check("t5_pop0_pre", ifc.vc0_pop, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_pop0_rst", ifc.vc0_pop, 1'b0);
        check("t5_pop1_rst", ifc.vc1_pop, 1'b0);
        check("t5_push_rst", ifc.d0_push, 1'b0);
        check("t5_data_rst", ifc.d_data, 6'h00);
        check("t5_gvc_rst", ifc.grant_vc, 1'b0);
        check("t5_cnt_rst", dut.burst_cnt_r, 3'd0);
        fill0 = 1'b0;
        fill1 = 1'b0;
        update_heads();
        @(posedge clk);
        #1;
        check("t5_no_inflight", ifc.d0_push | ifc.d1_push, 1'b0);
        #3;
        rst_n = 1'b1;
        #1;
        tick();
        check("t5_after_push", ifc.d0_push | ifc.d1_push, 1'b0);
        check("t5_after_blocked", ifc.blocked, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
